// File: rtl/rs232_pt_pkg.sv
// Shared constants for the RS232 passthrough monitor: mode encodings and a
// helper that sizes counters to hold a given maximum value.
package rs232_pt_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_PASS     = 2'b00;
  localparam logic [MODE_W-1:0] MODE_LOOPBACK = 2'b01;
  localparam logic [MODE_W-1:0] MODE_ISOLATE  = 2'b10;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rs232_line_conditioner.sv
// One RS232 line: 2-flop synchroniser, glitch filter, stretched activity,
// break detection and a saturating falling-edge counter.
module rs232_line_conditioner
  import rs232_pt_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned STRETCH_CYCLES = 2500000,
  parameter int unsigned BREAK_CYCLES   = 100000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             line_i,
  input  logic             cnt_clr_i,
  output logic             line_f_o,
  output logic             act_o,
  output logic             break_o,
  output logic [CNT_W-1:0] fall_cnt_o
);

  localparam int unsigned FW = cnt_width(FILTER_CYCLES);
  localparam int unsigned SW = cnt_width(STRETCH_CYCLES);
  localparam int unsigned BW = cnt_width(BREAK_CYCLES);

  localparam logic [FW-1:0] FILT_LAST   = FW'((FILTER_CYCLES == 0) ? 0 : FILTER_CYCLES - 1);
  localparam logic [SW-1:0] STRETCH_MAX = SW'(STRETCH_CYCLES);
  localparam logic [BW-1:0] BREAK_MAX   = BW'(BREAK_CYCLES);

  logic [1:0]       sync_d, sync_q;
  logic             filt_d, filt_q;
  logic             prev_d, prev_q;
  logic [FW-1:0]    fcnt_d, fcnt_q;
  logic [SW-1:0]    stretch_d, stretch_q;
  logic [BW-1:0]    brk_cnt_d, brk_cnt_q;
  logic [CNT_W-1:0] fall_d, fall_q;
  logic             sync_s;
  logic             line_f;

  assign sync_s = sync_q[1];
  // A zero-length filter hands the synchroniser output straight through.
  assign line_f = (FILTER_CYCLES == 0) ? sync_s : filt_q;

  always_comb begin
    sync_d    = {sync_q[0], line_i};
    filt_d    = filt_q;
    fcnt_d    = fcnt_q;
    prev_d    = line_f;
    stretch_d = stretch_q;
    brk_cnt_d = '0;
    fall_d    = fall_q;

    if (sync_s == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FILT_LAST) begin
      filt_d = sync_s;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end

    if (line_f != prev_q) begin
      stretch_d = STRETCH_MAX;
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - 1'b1;
    end

    if (!line_f) begin
      brk_cnt_d = (brk_cnt_q == BREAK_MAX) ? brk_cnt_q : brk_cnt_q + 1'b1;
    end

    // Clear has priority over a coincident falling edge.
    if (cnt_clr_i) begin
      fall_d = '0;
    end else if (prev_q && !line_f && (fall_q != '1)) begin
      fall_d = fall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= 2'b11;
      filt_q    <= 1'b1;
      prev_q    <= 1'b1;
      fcnt_q    <= '0;
      stretch_q <= '0;
      brk_cnt_q <= '0;
      fall_q    <= '0;
    end else begin
      sync_q    <= sync_d;
      filt_q    <= filt_d;
      prev_q    <= prev_d;
      fcnt_q    <= fcnt_d;
      stretch_q <= stretch_d;
      brk_cnt_q <= brk_cnt_d;
      fall_q    <= fall_d;
    end
  end

  assign line_f_o   = line_f;
  assign act_o      = (stretch_q != '0);
  assign break_o    = (brk_cnt_q == BREAK_MAX);
  assign fall_cnt_o = fall_q;

endmodule

// File: rtl/rs232_passthrough_monitor.sv
// Multi-channel RS232 passthrough with per-channel mode select (pass,
// loopback, isolate) and per-direction line monitoring.
module rs232_passthrough_monitor
  import rs232_pt_pkg::*;
#(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned STRETCH_CYCLES = 2500000,
  parameter int unsigned BREAK_CYCLES   = 100000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  input  logic [MODE_W*CHANNELS-1:0] MODE,
  input  logic [CHANNELS-1:0]       DTE_IN,
  input  logic [CHANNELS-1:0]       DCE_IN,
  output logic [CHANNELS-1:0]       DCE_OUT,
  output logic [CHANNELS-1:0]       DTE_OUT,
  output logic [CHANNELS-1:0]       ACT_DTE,
  output logic [CHANNELS-1:0]       ACT_DCE,
  output logic [CHANNELS-1:0]       BREAK_DTE,
  output logic [CHANNELS-1:0]       BREAK_DCE,
  input  logic [CHANNELS-1:0]       CNT_CLR,
  output logic [CNT_W*CHANNELS-1:0] FALL_CNT_DTE,
  output logic [CNT_W*CHANNELS-1:0] FALL_CNT_DCE
);

  logic [CHANNELS-1:0] f_dte, f_dce;
  logic [CHANNELS-1:0] dce_out_d, dce_out_q;
  logic [CHANNELS-1:0] dte_out_d, dte_out_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    rs232_line_conditioner #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .STRETCH_CYCLES(STRETCH_CYCLES),
      .BREAK_CYCLES  (BREAK_CYCLES),
      .CNT_W         (CNT_W)
    ) u_dte (
      .clk_i     (CLOCK_50),
      .rst_i     (RESET),
      .line_i    (DTE_IN[i]),
      .cnt_clr_i (CNT_CLR[i]),
      .line_f_o  (f_dte[i]),
      .act_o     (ACT_DTE[i]),
      .break_o   (BREAK_DTE[i]),
      .fall_cnt_o(FALL_CNT_DTE[i*CNT_W +: CNT_W])
    );

    rs232_line_conditioner #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .STRETCH_CYCLES(STRETCH_CYCLES),
      .BREAK_CYCLES  (BREAK_CYCLES),
      .CNT_W         (CNT_W)
    ) u_dce (
      .clk_i     (CLOCK_50),
      .rst_i     (RESET),
      .line_i    (DCE_IN[i]),
      .cnt_clr_i (CNT_CLR[i]),
      .line_f_o  (f_dce[i]),
      .act_o     (ACT_DCE[i]),
      .break_o   (BREAK_DCE[i]),
      .fall_cnt_o(FALL_CNT_DCE[i*CNT_W +: CNT_W])
    );
  end

  // Outputs idle at mark (1) unless the mode routes a filtered line to them.
  always_comb begin
    dce_out_d = '1;
    dte_out_d = '1;
    for (int i = 0; i < CHANNELS; i++) begin
      case (MODE[i*MODE_W +: MODE_W])
        MODE_PASS: begin
          dce_out_d[i] = f_dte[i];
          dte_out_d[i] = f_dce[i];
        end
        MODE_LOOPBACK: dte_out_d[i] = f_dte[i];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      dce_out_q <= '1;
      dte_out_q <= '1;
    end else begin
      dce_out_q <= dce_out_d;
      dte_out_q <= dte_out_d;
    end
  end

  assign DCE_OUT = dce_out_q;
  assign DTE_OUT = dte_out_q;

endmodule

// File: tb/tb_rs232_passthrough_monitor.sv
// Randomized bench for rs232_passthrough_monitor, checked every cycle against
// an event-timestamp reference model of each line.
module tb_rs232_passthrough_monitor;

  localparam int unsigned CH   = 4;
  localparam int unsigned FILT = 4;
  localparam int unsigned STR  = 10;
  localparam int unsigned BRK  = 100;
  localparam int unsigned CW   = 4;
  localparam int unsigned NL   = 2 * CH;
  localparam int unsigned CMAX = (1 << CW) - 1;
  localparam longint      NEVER = -1000000;

  logic              clk = 1'b0;
  logic              rst;
  logic [2*CH-1:0]   mode;
  logic [CH-1:0]     dte_in, dce_in, clr;
  logic [CH-1:0]     dce_out, dte_out, act_dte, act_dce, brk_dte, brk_dce;
  logic [CW*CH-1:0]  fc_dte, fc_dce;
  logic [NL-1:0]     pins;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign dte_in = pins[CH-1:0];
  assign dce_in = pins[NL-1:CH];

  rs232_passthrough_monitor #(
    .CHANNELS      (CH),
    .FILTER_CYCLES (FILT),
    .STRETCH_CYCLES(STR),
    .BREAK_CYCLES  (BRK),
    .CNT_W         (CW)
  ) u_dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .MODE        (mode),
    .DTE_IN      (dte_in),
    .DCE_IN      (dce_in),
    .DCE_OUT     (dce_out),
    .DTE_OUT     (dte_out),
    .ACT_DTE     (act_dte),
    .ACT_DCE     (act_dce),
    .BREAK_DTE   (brk_dte),
    .BREAK_DCE   (brk_dce),
    .CNT_CLR     (clr),
    .FALL_CNT_DTE(fc_dte),
    .FALL_CNT_DCE(fc_dce)
  );

  // Reference model; line l < CH is the DTE line of channel l, else DCE of l-CH.
  bit          m_s1[NL], m_s2[NL], m_f[NL];
  int unsigned m_run[NL], m_cnt[NL];
  longint      m_chg[NL], m_fall[NL];
  longint      k = 0;
  bit          e_act[NL], e_brk[NL];
  logic [CH-1:0] e_dce_out, e_dte_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    int m;
    k++;
    if (rst) begin
      for (int l = 0; l < NL; l++) begin
        m_s1[l] = 1'b1; m_s2[l] = 1'b1; m_f[l] = 1'b1;
        m_run[l] = 0; m_cnt[l] = 0;
        m_chg[l] = NEVER; m_fall[l] = NEVER;
        e_act[l] = 1'b0; e_brk[l] = 1'b0;
      end
      e_dce_out = '1;
      e_dte_out = '1;
      return;
    end
    for (int i = 0; i < CH; i++) begin
      m = int'(mode[2*i +: 2]);
      e_dce_out[i] = (m == 0) ? m_f[i] : 1'b1;
      e_dte_out[i] = (m == 0) ? m_f[CH+i] : (m == 1) ? m_f[i] : 1'b1;
    end
    for (int l = 0; l < NL; l++) begin
      e_act[l] = (k - m_chg[l] >= 1) && (k - m_chg[l] <= STR);
      e_brk[l] = (m_f[l] == 1'b0) && (k - m_fall[l] >= BRK);
      if (clr[l % CH]) m_cnt[l] = 0;
      else if (m_fall[l] == k - 1 && m_cnt[l] < CMAX) m_cnt[l]++;
      // Accept the synchronised value once it has disagreed for FILT samples.
      if (m_s2[l] != m_f[l]) begin
        m_run[l]++;
        if (m_run[l] == FILT) begin
          m_f[l] = m_s2[l];
          m_run[l] = 0;
          m_chg[l] = k;
          if (!m_f[l]) m_fall[l] = k;
        end
      end else begin
        m_run[l] = 0;
      end
      m_s2[l] = m_s1[l];
      m_s1[l] = pins[l];
    end
  endtask

  task automatic compare();
    logic [CH-1:0]    ea_dte, ea_dce, eb_dte, eb_dce;
    logic [CW*CH-1:0] ec_dte, ec_dce;
    for (int i = 0; i < CH; i++) begin
      ea_dte[i] = e_act[i];
      ea_dce[i] = e_act[CH+i];
      eb_dte[i] = e_brk[i];
      eb_dce[i] = e_brk[CH+i];
      ec_dte[i*CW +: CW] = CW'(m_cnt[i]);
      ec_dce[i*CW +: CW] = CW'(m_cnt[CH+i]);
    end
    check("dce_out", 64'(dce_out), 64'(e_dce_out));
    check("dte_out", 64'(dte_out), 64'(e_dte_out));
    check("act_dte", 64'(act_dte), 64'(ea_dte));
    check("act_dce", 64'(act_dce), 64'(ea_dce));
    check("break_dte", 64'(brk_dte), 64'(eb_dte));
    check("break_dce", 64'(brk_dce), 64'(eb_dce));
    check("fall_cnt_dte", 64'(fc_dte), 64'(ec_dte));
    check("fall_cnt_dce", 64'(fc_dce), 64'(ec_dce));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    int hold[NL];
    int r;
    int j;
    rst  = 1'b1;
    mode = '0;
    pins = '1;
    clr  = '0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Pin-to-output latency in PASS with a 4-cycle filter.
    pins[0] = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("lat6_dce_out0", 64'(dce_out[0]), 64'd1);
    step();
    check("lat7_dce_out0", 64'(dce_out[0]), 64'd0);
    check("lat7_fall_cnt0", 64'(fc_dte[CW-1:0]), 64'd1);

    for (int l = 0; l < NL; l++) hold[l] = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = (c == 2500);
      for (int l = 0; l < NL; l++) begin
        if (hold[l] == 0) begin
          r = int'($urandom_range(0, 19));
          pins[l] = ~pins[l];
          if (r == 0)     hold[l] = int'($urandom_range(100, 140));
          else if (r < 7) hold[l] = int'($urandom_range(1, 3));
          else            hold[l] = int'($urandom_range(4, 12));
        end else begin
          hold[l]--;
        end
      end
      for (int i = 0; i < CH; i++) clr[i] = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 149) == 0) begin
        j = int'($urandom_range(0, CH - 1));
        mode[2*j +: 2] = 2'($urandom_range(0, 3));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
